alarm_button_conditioner: RTL and testbench
===========================================

# alarm_button_conditioner

Conditions the eight raw push-button/switch inputs of the alarm clock before they reach the Avalon input PIO. Each bit is synchronised into `clk`, debounced, and presented as a clean level on `btn_level`, which drives the PIO `in_port` directly. The block also emits one-cycle press, release and auto-repeat pulses for the time-set logic, so a held set button advances the hour or minute at a fixed rate.

## Interface
- `WIDTH`, 8: number of button bits.
- `ACTIVE_LOW`, 1: 1 means a pressed button reads 0 on `btn_raw`, and the block inverts it internally.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Must be ≥1.
- `REPEAT_DELAY`, 25000000: cycles from a press to the first repeat pulse (500 ms). Must be ≥1.
- `REPEAT_RATE`, 5000000: cycles between subsequent repeat pulses (100 ms). Must be ≥1.
- `REPEAT_MASK`, 8'h0F: bit i = 1 enables auto-repeat on button i.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  WIDTH  asynchronous button/switch pins.
- `btn_level`  out  WIDTH  debounced level; 1 = pressed. Feeds PIO `in_port`.
- `btn_press`  out  WIDTH  one-cycle pulse when the debounced level goes 0→1.
- `btn_release`  out  WIDTH  one-cycle pulse when the debounced level goes 1→0.
- `btn_repeat`  out  WIDTH  one-cycle auto-repeat pulse while a masked button is held.

## Operation
- All outputs are registered.
- Reset values: all outputs 0, synchroniser stages 0 (released, after polarity correction), all counters 0, all repeat FSMs in IDLE.
- Per bit, polarity correction: `p = btn_raw[i] ^ ACTIVE_LOW`.
- Per bit, two-flop synchroniser: `s1 <= p`, then `s2 <= s1`.
- Debounce, per bit, with counter width `$clog2(DEBOUNCE_CYCLES)` (minimum 1):
  - If `s2 == level`, the counter clears to 0.
  - If they differ and the counter is below `DEBOUNCE_CYCLES-1`, the counter increments.
  - If they differ and the counter equals `DEBOUNCE_CYCLES-1`, then `level <= s2` and the counter clears.
  - Any bounce back to the old level before acceptance restarts the count from 0.
- Pulses: `btn_press[i]` / `btn_release[i]` are asserted on exactly the same edge that `btn_level[i]` rises or falls, for one cycle.
- Repeat FSM, per bit, only where `REPEAT_MASK[i] = 1`. Unmasked bits hold `btn_repeat[i] = 0` and need no FSM. States are IDLE, DELAY and RPT; the hold counter is sized for `max(REPEAT_DELAY, REPEAT_RATE)`.
  - IDLE → DELAY on the press edge; the hold counter is set to 0.
  - DELAY: the counter increments each cycle while held. At `REPEAT_DELAY-1`, pulse `btn_repeat`, clear the counter, go to RPT.
  - RPT: the counter increments each cycle. At `REPEAT_RATE-1`, pulse `btn_repeat` and clear the counter.
  - DELAY/RPT → IDLE on the release edge.
- Simultaneous events:
  - Release wins over a due repeat: no repeat pulse is emitted on the release edge.
  - `btn_press` and `btn_repeat` are never asserted together.
- Bits are fully independent; any combination may change in the same cycle.
- Reset mid-operation clears everything immediately. A button still held when reset deasserts produces a normal press after debounce.

## Timing
- Edge 1 is the first clock edge that samples a new, thereafter-stable `btn_raw` value. `btn_level` changes at edge `DEBOUNCE_CYCLES+2`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles, measured at `s2`, never changes `btn_level`.
- With the press pulse at edge P:
  - Repeat pulses occur at edges P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_RATE, and so on.
  - Pulses continue while held, with no limit and with counter wrap-around handled by the clear-on-match rule.
- There is no handshake. Consumers sample pulses on the cycle they are high.
- `btn_level` is stable for at least `DEBOUNCE_CYCLES` cycles between changes, so PIO reads are glitch-free.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_RATE=5`, `ACTIVE_LOW=1` and `REPEAT_MASK=8'h0F`.
- **Clean press.** Drive `btn_raw[0]` 1→0 and hold. Required: `btn_level[0]=1` and a single `btn_press[0]` pulse at edge 6; no other bits change.
- **Bounce rejection.** Toggle `btn_raw[1]` low for 3 cycles, high for 1, low for 3, then high. Required: `btn_level[1]` stays 0 and there are no pulses.
- **Auto-repeat.** Hold `btn_raw[2]` low for 60 cycles after the press at edge P. Required: `btn_repeat[2]` pulses at P+20, P+25, P+30, P+35, and so on. On release, one `btn_release[2]` pulse and no repeat on that edge.
- **Unmasked hold.** Hold `btn_raw[7]` low for 60 cycles. Required: press at edge 6, `btn_repeat[7]` is never asserted, and release behaves normally.
- **Reset mid-hold.** Assert `reset_n=0` during the RPT state. Required: all outputs are 0 immediately. Deassert with the button still held: a new press at edge 6 after deassertion, and the first repeat at P+20.
- **Simultaneous buttons.** Press bits 0 and 4 on the same cycle. Required: both levels rise and both press pulses assert on the same edge.

Source files
------------

// File: rtl/alarm_button_conditioner.sv
// Alarm clock button conditioner: per-bit synchroniser, debounce, press/release
// pulses and optional auto-repeat for held time-set buttons.
module alarm_button_conditioner #(
  parameter int unsigned      WIDTH           = 8,
  parameter bit               ACTIVE_LOW      = 1'b1,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      REPEAT_DELAY    = 25000000,
  parameter int unsigned      REPEAT_RATE     = 5000000,
  parameter logic [WIDTH-1:0] REPEAT_MASK     = WIDTH'(8'h0F)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_repeat
);

  localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_accept;

    // The synchronised sample has disagreed with the level long enough to take over.
    assign w_accept = (r_s2 != r_level) && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_db_cnt  <= '0;
      end else begin
        r_s1      <= btn_raw[i] ^ ACTIVE_LOW;
        r_s2      <= r_s1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (w_accept) begin
          r_level   <= r_s2;
          r_db_cnt  <= '0;
          r_press   <= r_s2;
          r_release <= ~r_s2;
        end else if (r_s2 == r_level) begin
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end

    assign btn_level[i]   = r_level;
    assign btn_press[i]   = r_press;
    assign btn_release[i] = r_release;

    if (REPEAT_MASK[i]) begin : g_rpt
      rpt_state_t        r_state;
      logic [HOLD_W-1:0] r_hold;
      logic              r_repeat;
      logic              w_rise;
      logic              w_fall;

      assign w_rise = w_accept & r_s2;
      assign w_fall = w_accept & ~r_s2;

      // Release takes priority over a repeat that falls due on the same edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state  <= IDLE;
          r_hold   <= '0;
          r_repeat <= 1'b0;
        end else begin
          r_repeat <= 1'b0;
          case (r_state)
            IDLE: begin
              if (w_rise) begin
                r_state <= DELAY;
                r_hold  <= '0;
              end
            end
            DELAY: begin
              if (w_fall) begin
                r_state <= IDLE;
              end else if (r_hold == DELAY_LAST) begin
                r_repeat <= 1'b1;
                r_hold   <= '0;
                r_state  <= RPT;
              end else begin
                r_hold <= r_hold + HOLD_W'(1);
              end
            end
            RPT: begin
              if (w_fall) begin
                r_state <= IDLE;
              end else if (r_hold == RATE_LAST) begin
                r_repeat <= 1'b1;
                r_hold   <= '0;
              end else begin
                r_hold <= r_hold + HOLD_W'(1);
              end
            end
            default: begin
              r_state <= IDLE;
              r_hold  <= '0;
            end
          endcase
        end
      end

      assign btn_repeat[i] = r_repeat;
    end else begin : g_no_rpt
      assign btn_repeat[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_alarm_button_conditioner.sv
// Randomised and directed bench for alarm_button_conditioner, checked against a
// sample-window / elapsed-time reference model.
module tb_alarm_button_conditioner;

  localparam int unsigned W    = 8;
  localparam int          DB   = 4;
  localparam int          RD   = 20;
  localparam int          RR   = 5;
  localparam logic [W-1:0] MASK = 8'h0F;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] raw = '1;
  logic [W-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model state: polarity-corrected samples (newest first), level, press time.
  logic [W-1:0] hist[$];
  logic [W-1:0] lvl = '0;
  int           press_cyc[W];

  alarm_button_conditioner #(
    .WIDTH(W), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  function automatic logic [W-1:0] samp(input int n);
    return (n < hist.size()) ? hist[n] : '0;
  endfunction

  // One clock: advance the model using the value seen at the edge, then compare.
  task automatic tick();
    logic [W-1:0] nl, e_p, e_r, e_rep;
    logic [W-1:0] s;
    bit all1, all0;
    int el;
    @(posedge clk);
    #1;
    cyc++;
    hist.push_front(~raw);
    if (hist.size() > DB + 2) void'(hist.pop_back());
    for (int i = 0; i < int'(W); i++) begin
      all1 = 1'b1;
      all0 = 1'b1;
      for (int n = 2; n <= DB + 1; n++) begin
        s = samp(n);
        all1 = all1 & s[i];
        all0 = all0 & ~s[i];
      end
      nl[i] = all1 ? 1'b1 : (all0 ? 1'b0 : lvl[i]);
      e_p[i] = nl[i] & ~lvl[i];
      e_r[i] = ~nl[i] & lvl[i];
      if (e_p[i]) press_cyc[i] = cyc;
      el = cyc - press_cyc[i];
      e_rep[i] = MASK[i] && lvl[i] && nl[i] && (el >= RD) && (((el - RD) % RR) == 0);
    end
    lvl = nl;
    check("level",   32'(btn_level),   32'(lvl));
    check("press",   32'(btn_press),   32'(e_p));
    check("release", 32'(btn_release), 32'(e_r));
    check("repeat",  32'(btn_repeat),  32'(e_rep));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_level",   32'(btn_level),   32'd0);
    check("rst_press",   32'(btn_press),   32'd0);
    check("rst_release", 32'(btn_release), 32'd0);
    check("rst_repeat",  32'(btn_repeat),  32'd0);
    hist.delete();
    lvl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic settle(input int n);
    raw = '1;
    repeat (n) tick();
  endtask

  initial begin
    #3;
    do_reset();
    repeat (3) tick();

    // Clean press on bit 0: level and press at edge 6.
    raw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("clean_lvl0", 32'(btn_level[0]), 32'(k == 6));
      check("clean_prs0", 32'(btn_press[0]), 32'(k == 6));
    end
    repeat (5) tick();
    settle(10);

    // Bounce on bit 1: never accepted.
    for (int k = 0; k < 8; k++) begin
      raw[1] = (k == 3 || k == 7) ? 1'b1 : 1'b0;
      tick();
      check("bounce_lvl1", 32'(btn_level[1]), 32'd0);
    end
    repeat (8) begin
      tick();
      check("bounce_lvl1", 32'(btn_level[1]), 32'd0);
    end

    // Auto-repeat on bit 2, released so the release edge coincides with a due repeat.
    raw[2] = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      if (k == 61) raw[2] = 1'b1;
      tick();
      if (k < 66)
        check("rpt2", 32'(btn_repeat[2]), 32'(k >= 26 && ((k - 26) % 5) == 0));
      else begin
        check("rel2_pulse", 32'(btn_release[2]), 32'd1);
        check("rel2_norpt", 32'(btn_repeat[2]), 32'd0);
      end
    end
    settle(10);

    // Unmasked bit 7 held: press at 6, never repeats.
    raw[7] = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      check("unmask_prs7", 32'(btn_press[7]), 32'(k == 6));
      check("unmask_rpt7", 32'(btn_repeat[7]), 32'd0);
    end
    settle(10);

    // Reset mid-hold on bit 3, then a fresh press and first repeat after deassertion.
    raw[3] = 1'b0;
    repeat (40) tick();
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      tick();
      check("rst_prs3", 32'(btn_press[3]), 32'(k == 6));
      check("rst_rpt3", 32'(btn_repeat[3]), 32'(k == 26));
    end
    settle(10);

    // Bits 0 and 4 pressed together.
    raw[0] = 1'b0;
    raw[4] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("simul_prs", 32'(btn_press & 8'h11), (k == 6) ? 32'h11 : 32'h0);
    end
    settle(10);

    // Random: slow toggling (holds long enough to repeat), then bouncy toggling.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < int'(W); i++)
        if ($urandom_range(0, (c < 1500) ? 40 : 4) == 0) raw[i] = ~raw[i];
      tick();
    end
    settle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
